iir_notch_biquad: RTL



---
 rtl/iir_notch_pkg.sv | 20 ++
 rtl/iir_mac_unit.sv | 34 +++
 rtl/iir_notch_biquad.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/iir_notch_pkg.sv
// Shared types and helpers for the Direct Form I notch biquad.
package iir_notch_pkg;

  typedef enum logic [1:0] {WAIT_IN, MAC, ROUND, OUT} state_t;

  // One MAC tap per history term: b0, b1, b2, a1, a2
  typedef logic [2:0] tap_t;
  localparam tap_t LAST_TAP = 3'd4;

  // Product width plus 3 guard bits for the five-term sum
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

  // Half an LSB of the output, used for round-half-up before the shift
  function automatic longint round_const(input int frac);
    return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Single shared multiplier with an add/subtract accumulator.
module iir_mac_unit
  import iir_notch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = 18,
  parameter int ACC_W  = acc_width(32, 18)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = COEF_W + DATA_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod     = coef * data;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Accumulate (or subtract for feedback taps); clear starts a new sample
  always_ff @(posedge clk) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
  end

endmodule

// File: rtl/iir_notch_biquad.sv
// Direct Form I notch biquad, one sample per stb/ack handshake, 5 MAC
// cycles on a shared multiplier. Build option IIR_NOTCH_SAT_EN saturates the
// rounded result to DATA_W; otherwise it wraps.
module iir_notch_biquad
  import iir_notch_pkg::*;
#(
  parameter int                       DATA_W    = 32,
  parameter int                       COEF_W    = 18,
  parameter int                       COEF_FRAC = 14,
  parameter logic signed [COEF_W-1:0] B0        = COEF_W'(16384),
  parameter logic signed [COEF_W-1:0] B1        = COEF_W'(0),
  parameter logic signed [COEF_W-1:0] B2        = COEF_W'(16384),
  parameter logic signed [COEF_W-1:0] A1        = COEF_W'(0),
  parameter logic signed [COEF_W-1:0] A2        = COEF_W'(13271)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] input_a,
  input  logic                     input_a_stb,
  output logic                     input_a_ack,
  output logic signed [DATA_W-1:0] output_z,
  output logic                     output_z_stb,
  input  logic                     output_z_ack
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(COEF_FRAC));

  state_t state, nstate;
  tap_t   tap;

  logic signed [DATA_W-1:0] x0, x1, x2, y1, y2;
  logic signed [ACC_W-1:0]  acc, acc_rnd, acc_sh;
  logic signed [DATA_W-1:0] r;

  logic                     accept, release_z;
  logic                     mac_en, mac_clr, mac_sub;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [DATA_W-1:0] mac_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IN;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      WAIT_IN: if (input_a_stb && input_a_ack)   nstate = MAC;
      MAC:     if (tap == LAST_TAP)              nstate = ROUND;
      ROUND:                                     nstate = OUT;
      OUT:     if (output_z_stb && output_z_ack) nstate = WAIT_IN;
      default:                                   nstate = WAIT_IN;
    endcase
  end

  // Handshake qualifiers and per-tap coefficient/operand selection
  always_comb begin
    accept    = (state == WAIT_IN) && input_a_stb && input_a_ack;
    release_z = (state == OUT) && output_z_stb && output_z_ack;
    mac_clr   = accept;
    mac_en    = (state == MAC);
    mac_sub   = 1'b0;
    mac_coef  = B0;
    mac_data  = x0;
    case (tap)
      3'd0:    begin mac_coef = B0; mac_data = x0; end
      3'd1:    begin mac_coef = B1; mac_data = x1; end
      3'd2:    begin mac_coef = B2; mac_data = x2; end
      3'd3:    begin mac_coef = A1; mac_data = y1; mac_sub = 1'b1; end
      default: begin mac_coef = A2; mac_data = y2; mac_sub = 1'b1; end
    endcase
  end

  iir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .sub  (mac_sub),
    .coef (mac_coef),
    .data (mac_data),
    .acc  (acc)
  );

  assign acc_rnd = acc + RND;
  assign acc_sh  = acc_rnd >>> COEF_FRAC;

`ifdef IIR_NOTCH_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp the rounded result into the sample range
  always_comb begin
    r = DATA_W'(acc_sh);
    if (acc_sh > SAT_MAX)      r = DATA_W'(SAT_MAX);
    else if (acc_sh < SAT_MIN) r = DATA_W'(SAT_MIN);
  end
`else
  // Keep the low DATA_W bits: two's-complement wrap on overflow
  always_comb begin
    r = DATA_W'(acc_sh);
  end
`endif

  // Datapath: capture, tap sequencing, rounding, history and handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      tap          <= '0;
      x0           <= '0;
      x1           <= '0;
      x2           <= '0;
      y1           <= '0;
      y2           <= '0;
    end else begin
      case (state)
        WAIT_IN: begin
          if (accept) begin
            x0          <= input_a;
            input_a_ack <= 1'b0;
            tap         <= '0;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        MAC: tap <= tap + 3'd1;
        ROUND: begin
          output_z     <= r;
          output_z_stb <= 1'b1;
          x2           <= x1;
          x1           <= x0;
          y2           <= y1;
          y1           <= r;
        end
        OUT: begin
          if (release_z) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
